// File: rtl/disp_pkg.sv
// Shared register map, CTRL bit positions, FSM state type and blank segment pattern
// for the 7-segment scroll controller.
package disp_pkg;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_RATE = 2'd1;
    localparam logic [1:0] REG_DATA = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE    = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_BLINK   = 3;
    localparam int CTRL_LEN_LSB = 4;
    localparam int CTRL_BUSY    = 8;
    localparam int STAT_PEND    = 0;
    localparam int HEAD_LSB     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STATIC = 2'd1,
        SCROLL = 2'd2
    } state_t;

    // Blank digit for active-low segments; active-high builds use its inverse.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to 7-segment decoder (bit0 = a .. bit6 = g).
// Table is stored active-low and inverted for active-high panels.
module seg7_decode #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    logic [6:0] lit_low;

    always_comb begin
        case (hex)
            4'h0: lit_low = 7'h40;
            4'h1: lit_low = 7'h79;
            4'h2: lit_low = 7'h24;
            4'h3: lit_low = 7'h30;
            4'h4: lit_low = 7'h19;
            4'h5: lit_low = 7'h12;
            4'h6: lit_low = 7'h02;
            4'h7: lit_low = 7'h78;
            4'h8: lit_low = 7'h00;
            4'h9: lit_low = 7'h10;
            4'hA: lit_low = 7'h08;
            4'hB: lit_low = 7'h03;
            4'hC: lit_low = 7'h46;
            4'hD: lit_low = 7'h21;
            4'hE: lit_low = 7'h06;
            default: lit_low = 7'h0E;
        endcase
    end

    assign seg = SEG_ACTIVE_LOW ? lit_low : ~lit_low;

endmodule

// File: rtl/display_scroll_ctrl.sv
// Avalon-MM controlled 7-segment message display: static or scrolling nibble buffer with wrap IRQ.
// Optional blink feature enabled by defining DISP_SCROLL_BLINK_EN.
//   state  | meaning
//   IDLE   | disabled, all digits blank
//   STATIC | buffer shown from entry 0, head held at 0
//   SCROLL | head advances one entry per prescaler expiry
module display_scroll_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int BUF_DEPTH      = 16,
    parameter int RATE_W         = 24,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  irq,
    output logic [7*N_DIGITS-1:0] out_port
);

    localparam int         PTR_W = $clog2(BUF_DEPTH);
    localparam logic [6:0] BLANK = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

    logic              ctrl_en, ctrl_mode, ctrl_irq_en, ctrl_blink;
    logic [3:0]        ctrl_len;
    logic [RATE_W-1:0] rate, prescaler;
    logic [PTR_W-1:0]  wr_ptr, head, disp_idx;
    logic [3:0]        buf_mem [BUF_DEPTH];
    logic              irq_pending, blank_all;
    state_t            state, state_next;
    logic              wr_en, wr_ctrl, step, wrap;
    logic [3:0]        digit_hex [N_DIGITS];
    logic [6:0]        digit_seg [N_DIGITS];
    logic              unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wr_ctrl   = wr_en && (address == REG_CTRL);
    assign step      = (state != IDLE) && (prescaler == '0);
    assign wrap      = step && (state == SCROLL) && (head == PTR_W'(ctrl_len));
    assign irq       = irq_pending & ctrl_irq_en;
    assign unused_wd = &{1'b0, writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        if (ctrl_en) state_next = ctrl_mode ? SCROLL : STATIC;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en     <= 1'b0;
            ctrl_mode   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ctrl_len    <= '0;
            rate        <= '0;
        end else if (wr_ctrl) begin
            ctrl_en     <= writedata[CTRL_EN];
            ctrl_mode   <= writedata[CTRL_MODE];
            ctrl_irq_en <= writedata[CTRL_IRQ_EN];
            ctrl_len    <= writedata[CTRL_LEN_LSB +: 4];
        end else if (wr_en && (address == REG_RATE)) begin
            rate <= writedata[RATE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
            wr_ptr <= '0;
        end else if (wr_en && (address == REG_DATA)) begin
            buf_mem[wr_ptr] <= writedata[3:0];
            wr_ptr          <= wr_ptr + PTR_W'(1);
        end
    end

    // A CTRL write while running restarts the message from entry 0 with a full step period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head      <= '0;
            prescaler <= '0;
        end else if (wr_ctrl && ctrl_en) begin
            head      <= '0;
            prescaler <= rate;
        end else begin
            if (wr_en && (address == REG_RATE)) prescaler <= writedata[RATE_W-1:0];
            else if ((state == IDLE) || step)   prescaler <= rate;
            else                                prescaler <= prescaler - RATE_W'(1);

            if (state != SCROLL) head <= '0;
            else if (step)       head <= wrap ? '0 : head + PTR_W'(1);
        end
    end

    // A wrap in the same cycle as a W1C clear keeps the interrupt pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                                      irq_pending <= 1'b0;
        else if (wrap)                                                     irq_pending <= 1'b1;
        else if (wr_en && (address == REG_STAT) && writedata[STAT_PEND])   irq_pending <= 1'b0;
    end

`ifdef DISP_SCROLL_BLINK_EN
    logic [2:0] blink_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_blink <= 1'b0;
            blink_cnt  <= '0;
        end else begin
            if (wr_ctrl) ctrl_blink <= writedata[CTRL_BLINK];
            if (step)    blink_cnt  <= blink_cnt + 3'd1;
        end
    end

    assign blank_all = ctrl_blink & blink_cnt[2];
`else
    assign ctrl_blink = 1'b0;
    assign blank_all  = 1'b0;
`endif

    // Leftmost digit shows head; each digit to the right is the next entry, wrapping at L.
    always_comb begin
        disp_idx = head;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            digit_hex[k] = buf_mem[disp_idx];
            disp_idx     = (disp_idx == PTR_W'(ctrl_len)) ? '0 : disp_idx + PTR_W'(1);
        end
    end

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        seg7_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
            .hex (digit_hex[k]),
            .seg (digit_seg[k])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= {N_DIGITS{BLANK}};
        end else begin
            for (int k = 0; k < N_DIGITS; k++)
                out_port[7*k +: 7] <= ((state == IDLE) || blank_all) ? BLANK : digit_seg[k];
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            REG_CTRL: begin
                readdata[CTRL_EN]           = ctrl_en;
                readdata[CTRL_MODE]         = ctrl_mode;
                readdata[CTRL_IRQ_EN]       = ctrl_irq_en;
                readdata[CTRL_BLINK]        = ctrl_blink;
                readdata[CTRL_LEN_LSB +: 4] = ctrl_len;
                readdata[CTRL_BUSY]         = (state != IDLE);
            end
            REG_RATE: readdata[RATE_W-1:0] = rate;
            REG_DATA: begin
                readdata[HEAD_LSB +: PTR_W] = head;
                readdata[PTR_W-1:0]         = wr_ptr;
            end
            default: begin
                readdata[HEAD_LSB +: PTR_W] = head;
                readdata[STAT_PEND]         = irq_pending;
            end
        endcase
    end

endmodule

// File: tb/tb_display_scroll_ctrl.sv
// Self-checking bench for display_scroll_ctrl: directed scenarios plus randomized traffic
// against a behavioural model of the register/scroll rules.
module tb_display_scroll_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        irq;
    logic [27:0] out_port;

    display_scroll_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] HEX7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [27:0] ALL_BLANK = 28'hFFFFFFF;

    int checks = 0;
    int failures = 0;

    // Behavioural model: st 0=off, 1=static, 2=scrolling
    int          m_buf [16];
    int          m_wp, m_len, m_rate, m_head, m_pre, m_st, m_bcnt;
    bit          m_en, m_mode, m_irqen, m_blink, m_pend;
    logic [27:0] m_out;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_buf[i] = 0;
        m_wp = 0; m_len = 0; m_rate = 0; m_head = 0; m_pre = 0; m_st = 0; m_bcnt = 0;
        m_en = 0; m_mode = 0; m_irqen = 0; m_blink = 0; m_pend = 0;
        m_out = ALL_BLANK;
    endtask

    function automatic logic [27:0] model_display();
        logic [27:0] o;
        int len1;
        len1 = m_len + 1;
        o = '0;
        for (int k = 0; k < 4; k++) begin
            if (m_st == 0 || (m_blink && m_bcnt >= 4)) o[7*k +: 7] = 7'h7F;
            else o[7*k +: 7] = HEX7[m_buf[(m_head + 3 - k) % len1]];
        end
        return o;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0: return {23'd0, (m_st != 0), 4'(m_len), m_blink, m_irqen, m_mode, m_en};
            2'd1: return 32'(m_rate);
            2'd2: return 32'((m_head << 8) | m_wp);
            default: return 32'((m_head << 8) | int'(m_pend));
        endcase
    endfunction

    function automatic bit model_irq();
        return m_pend && m_irqen;
    endfunction

    // Advance the model by one clock using the currently driven bus, then clock the DUT.
    task automatic step_clk();
        bit wr, tick, wrp;
        int len1, n_st, n_head, n_pre;
        logic [27:0] n_out;
        wr   = chipselect && !write_n;
        len1 = m_len + 1;
        tick = (m_st != 0) && (m_pre == 0);
        wrp  = tick && (m_st == 2) && (m_head == m_len);
        n_out = model_display();
        n_st  = m_en ? (m_mode ? 2 : 1) : 0;
        n_head = (m_st != 2) ? 0 : (tick ? (m_head + 1) % len1 : m_head);
        n_pre  = (m_st == 0 || tick) ? m_rate : m_pre - 1;
        if (wr && address == 2'd1) n_pre = int'(writedata[23:0]);
        if (wr && address == 2'd0 && m_en) begin n_head = 0; n_pre = m_rate; end
        if (wrp) m_pend = 1;
        else if (wr && address == 2'd3 && writedata[0]) m_pend = 0;
        if (tick) m_bcnt = (m_bcnt + 1) % 8;
        if (wr && address == 2'd0) begin
            m_en = writedata[0]; m_mode = writedata[1]; m_irqen = writedata[2];
`ifdef DISP_SCROLL_BLINK_EN
            m_blink = writedata[3];
`endif
            m_len = int'(writedata[7:4]);
        end
        if (wr && address == 2'd1) m_rate = int'(writedata[23:0]);
        if (wr && address == 2'd2) begin
            m_buf[m_wp] = int'(writedata[3:0]);
            m_wp = (m_wp + 1) % 16;
        end
        m_st = n_st; m_head = n_head; m_pre = n_pre; m_out = n_out;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step_clk();
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        address = 2'd0;
        #1;
        checks++;
        if (out_port !== ALL_BLANK) begin failures++; $display("FAIL reset_out_port got=%h exp=%h", out_port, ALL_BLANK); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++;
        if (readdata !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", readdata); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_static();
        for (int i = 1; i <= 4; i++) bus_write(2'd2, 32'(i));
        bus_write(2'd0, 32'h31);
        step_clk();
        step_clk();
        checks++;
        if (out_port !== {7'h79, 7'h24, 7'h30, 7'h19}) begin
            failures++; $display("FAIL static_digits got=%h exp=%h", out_port, {7'h79, 7'h24, 7'h30, 7'h19});
        end
        checks++;
        if (out_port !== m_out) begin failures++; $display("FAIL static_model got=%h exp=%h", out_port, m_out); end
        address = 2'd0;
        #1;
        checks++;
        if (readdata !== 32'h131) begin failures++; $display("FAIL static_ctrl_rd got=%h exp=%h", readdata, 32'h131); end
    endtask

    task automatic test_scroll();
        int seq[$];
        int last;
        bit saw_irq;
        last = -1;
        saw_irq = 0;
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'h37);
        for (int c = 0; c < 26; c++) begin
            step_clk();
            address = 2'd3;
            #1;
            checks++;
            if (readdata !== model_read(2'd3)) begin failures++; $display("FAIL scroll_stat c=%0d got=%h exp=%h", c, readdata, model_read(2'd3)); end
            checks++;
            if (out_port !== m_out) begin failures++; $display("FAIL scroll_out c=%0d got=%h exp=%h", c, out_port, m_out); end
            checks++;
            if (irq !== model_irq()) begin failures++; $display("FAIL scroll_irq c=%0d got=%b exp=%b", c, irq, model_irq()); end
            if (int'(readdata[11:8]) != last) begin last = int'(readdata[11:8]); seq.push_back(last); end
            if (irq === 1'b1) saw_irq = 1;
        end
        checks++;
        if (seq.size() < 5) begin failures++; $display("FAIL scroll_seq_len got=%0d exp>=5", seq.size()); end
        for (int i = 0; i < 5 && i < seq.size(); i++) begin
            checks++;
            if (seq[i] != i % 4) begin failures++; $display("FAIL scroll_seq i=%0d got=%0d exp=%0d", i, seq[i], i % 4); end
        end
        checks++;
        if (!saw_irq) begin failures++; $display("FAIL scroll_wrap_irq got=0 exp=1"); end
        bus_write(2'd3, 32'd1);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL scroll_w1c got=%b exp=0", irq); end
    endtask

    task automatic test_w1c_collision();
        bit found;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (m_st == 2 && m_pre == 0 && m_head == m_len) begin
                bus_write(2'd3, 32'd1);
                address = 2'd3;
                #1;
                found = 1;
                checks++;
                if (readdata[0] !== 1'b1) begin failures++; $display("FAIL w1c_collision_pend got=%b exp=1", readdata[0]); end
                checks++;
                if (irq !== 1'b1) begin failures++; $display("FAIL w1c_collision_irq got=%b exp=1", irq); end
            end else begin
                step_clk();
            end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL w1c_collision_timeout got=none exp=wrap"); end
    endtask

    task automatic test_len1();
        while (m_wp != 0) bus_write(2'd2, 32'd0);
        bus_write(2'd2, 32'd8);
        bus_write(2'd0, 32'h03);
        for (int c = 0; c < 3; c++) step_clk();
        checks++;
        if (out_port !== 28'h0) begin failures++; $display("FAIL len1_eights got=%h exp=0", out_port); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL len1_irq_masked got=%b exp=0", irq); end
        bus_write(2'd0, 32'h0);
        step_clk();
        address = 2'd0;
        #1;
        checks++;
        if (readdata[8] !== 1'b0) begin failures++; $display("FAIL len1_busy got=%b exp=0", readdata[8]); end
        step_clk();
        checks++;
        if (out_port !== ALL_BLANK) begin failures++; $display("FAIL len1_blank got=%h exp=%h", out_port, ALL_BLANK); end
    endtask

    task automatic test_random();
        logic [1:0] a;
        int op;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < int'($urandom_range(0, 20)); i++) bus_write(2'd2, $urandom);
            bus_write(2'd1, 32'($urandom_range(0, 4)));
            bus_write(2'd0, {24'd0, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1});
            for (int c = 0; c < 40; c++) begin
                op = int'($urandom_range(0, 11));
                if (op == 7)      bus_write(2'd2, $urandom);
                else if (op == 8) bus_write(2'd3, 32'd1);
                else if (op == 9) bus_write(2'd1, 32'($urandom_range(0, 4)));
                else              step_clk();
                a = 2'($urandom_range(0, 3));
                address = a;
                #1;
                checks++;
                if (readdata !== model_read(a)) begin failures++; $display("FAIL rand_read it=%0d a=%0d got=%h exp=%h", it, a, readdata, model_read(a)); end
                checks++;
                if (out_port !== m_out) begin failures++; $display("FAIL rand_out it=%0d c=%0d got=%h exp=%h", it, c, out_port, m_out); end
                checks++;
                if (irq !== model_irq()) begin failures++; $display("FAIL rand_irq it=%0d c=%0d got=%b exp=%b", it, c, irq, model_irq()); end
            end
        end
    endtask

`ifdef DISP_SCROLL_BLINK_EN
    task automatic test_blink();
        int blanks;
        blanks = 0;
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h49);
        for (int c = 0; c < 24; c++) begin
            step_clk();
            checks++;
            if (out_port !== m_out) begin failures++; $display("FAIL blink_out c=%0d got=%h exp=%h", c, out_port, m_out); end
            if (out_port === ALL_BLANK) blanks++;
        end
        checks++;
        if (blanks < 8 || blanks > 16) begin failures++; $display("FAIL blink_count got=%0d exp=8..16", blanks); end
    endtask
`endif

    task automatic test_reset_mid();
        bit found;
        found = 0;
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h37);
        for (int c = 0; c < 40 && !found; c++) begin
            step_clk();
            if (m_head == 2) found = 1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL reset_mid_head2 got=none exp=2"); end
        address = 2'd3;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out_port !== ALL_BLANK) begin failures++; $display("FAIL reset_mid_out got=%h exp=%h", out_port, ALL_BLANK); end
        checks++;
        if (readdata !== 32'd0) begin failures++; $display("FAIL reset_mid_stat got=%h exp=0", readdata); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_mid_irq got=%b exp=0", irq); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step_clk();
        checks++;
        if (out_port !== m_out) begin failures++; $display("FAIL reset_mid_after got=%h exp=%h", out_port, m_out); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_static();
        test_scroll();
        test_w1c_collision();
        test_len1();
        test_random();
`ifdef DISP_SCROLL_BLINK_EN
        test_blink();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
